// File: rtl/hr_pkg.sv
// hr_pkg: shared widths, constants and FSM state type for the heart rate meter
package hr_pkg;
    localparam int PERIOD_W = 12;
    localparam int BPM_W    = 8;
    localparam logic [15:0] BPM_NUMERATOR = 16'd60000;
    typedef enum logic {IDLE, MEASURE} state_t;
endpackage

// File: rtl/hr_divider.sv
// hr_divider: 16/12 restoring divider, one quotient bit per cycle; done strobes once the last bit is in
module hr_divider
    import hr_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [15:0]         dividend,
    input  logic [PERIOD_W-1:0] divisor,
    output logic                busy,
    output logic                done,
    output logic [15:0]         quotient
);
    logic [PERIOD_W-1:0] rem, dsr;
    logic [PERIOD_W:0]   shifted, diff;
    logic [4:0]          iter;
    assign busy    = iter != '0;
    assign shifted = {rem, quotient[15]};
    assign diff    = shifted - {1'b0, dsr};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem      <= '0;
            dsr      <= '0;
            quotient <= '0;
            iter     <= '0;
            done     <= 1'b0;
        end else if (start) begin
            rem      <= '0;
            dsr      <= divisor;
            quotient <= dividend;
            iter     <= 5'd16;
            done     <= 1'b0;
        end else begin
            done <= iter == 5'd1;
            if (busy) begin
                // diff MSB set means the trial subtraction went negative: restore
                quotient <= {quotient[14:0], ~diff[PERIOD_W]};
                rem      <= diff[PERIOD_W] ? shifted[PERIOD_W-1:0] : diff[PERIOD_W-1:0];
                iter     <= iter - 5'd1;
            end
        end
    end
endmodule

// File: rtl/heart_rate_meter.sv
// heart_rate_meter: times heartbeat pulse intervals in ms and converts them to bpm.
// Define HR_AVERAGE_EN to divide by the mean of the last four accepted periods.
module heart_rate_meter
    import hr_pkg::*;
#(
    parameter int CLK_HZ        = 100_000_000,
    parameter int TICK_HZ       = 1000,
    parameter int MIN_PERIOD_MS = 250,
    parameter int MAX_PERIOD_MS = 3000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pulse_in,
    output logic             beat,
    output logic [BPM_W-1:0] bpm,
    output logic             bpm_valid,
    output logic             timeout
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = DIV > 2 ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]       PRE_LAST = PW'(DIV - 1);
    localparam logic [PERIOD_W-1:0] MIN_P    = PERIOD_W'(MIN_PERIOD_MS);
    localparam logic [PERIOD_W-1:0] MAX_P    = PERIOD_W'(MAX_PERIOD_MS);
    logic [2:0]          sync;
    logic [PW-1:0]       pre;
    logic [PERIOD_W-1:0] count, divisor;
    logic                tick, rise, accept, timeout_hit, measure_acc, start, div_busy, div_done;
    logic [15:0]         quotient;
    state_t              state, state_nx;
    assign tick        = pre == PRE_LAST;
    assign rise        = sync[1] & ~sync[2];
    assign measure_acc = accept && state == MEASURE;
    always_comb begin
        state_nx    = state;
        accept      = 1'b0;
        timeout_hit = 1'b0;
        if (state == IDLE) begin
            accept   = rise;
            state_nx = rise ? MEASURE : IDLE;
        end else if (count == MAX_P) begin
            timeout_hit = 1'b1;
            state_nx    = IDLE;
        end else begin
            accept = rise && count >= MIN_P;
        end
    end
`ifdef HR_AVERAGE_EN
    logic [PERIOD_W-1:0] hist [3];
    logic [1:0]          hist_n;
    logic [PERIOD_W+1:0] sum;
    // the period being accepted now is the fourth member of the average
    assign sum     = {2'b0, hist[0]} + {2'b0, hist[1]} + {2'b0, hist[2]} + {2'b0, count};
    assign divisor = PERIOD_W'(sum >> 2);
    assign start   = measure_acc && hist_n == 2'd3 && !div_busy;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist   <= '{default: '0};
            hist_n <= '0;
        end else if (timeout_hit) begin
            hist   <= '{default: '0};
            hist_n <= '0;
        end else if (measure_acc) begin
            hist   <= '{count, hist[0], hist[1]};
            hist_n <= hist_n + 2'(hist_n != 2'd3);
        end
    end
`else
    assign divisor = count;
    assign start   = measure_acc && !div_busy;
`endif
    hr_divider u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .dividend (BPM_NUMERATOR),
        .divisor  (divisor),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (quotient)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync      <= '0;
            pre       <= '0;
            count     <= '0;
            state     <= IDLE;
            beat      <= 1'b0;
            bpm       <= '0;
            bpm_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            sync      <= {sync[1:0], pulse_in};
            pre       <= tick ? '0 : pre + 1'b1;
            count     <= accept ? '0 : (tick && count != MAX_P) ? count + 1'b1 : count;
            state     <= state_nx;
            beat      <= accept;
            timeout   <= accept ? 1'b0 : (timeout_hit ? 1'b1 : timeout);
            bpm_valid <= timeout_hit ? 1'b0 : (div_done ? 1'b1 : bpm_valid);
            if (div_done)
                bpm <= |quotient[15:BPM_W] ? '1 : quotient[BPM_W-1:0];
        end
    end
endmodule

// File: tb/tb_heart_rate_meter.sv
// tb_heart_rate_meter: checks heart_rate_meter against an interval-arithmetic model; build with
// and without HR_AVERAGE_EN. Two clocks per ms keeps the long heartbeat intervals cheap to simulate.
module tb_heart_rate_meter;
    localparam int DIV  = 2;
    localparam int MINP = 250;
    localparam int MAXP = 3000;
`ifdef HR_AVERAGE_EN
    localparam bit AVG = 1'b1;
`else
    localparam bit AVG = 1'b0;
`endif
    logic       clk = 1'b0, rst_n = 1'b0, pulse_in = 1'b0;
    logic       beat, bpm_valid, timeout;
    logic [7:0] bpm;
    int rc, n_chk, n_fail, beats;
    int q[$], per[$];
    int a_edge, pend_at = -1, pend_val, m_bpm;
    bit m_meas, m_to, m_valid, m_beat;

    heart_rate_meter #(.CLK_HZ(2000), .TICK_HZ(1000), .MIN_PERIOD_MS(MINP), .MAX_PERIOD_MS(MAXP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pulse_in  (pulse_in),
        .beat      (beat),
        .bpm       (bpm),
        .bpm_valid (bpm_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    // clock edges since reset release; ms ticks land on edges that are multiples of DIV
    always @(posedge clk or negedge rst_n) rc <= !rst_n ? 0 : rc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, rc, act, exp);
        end
    endtask

    always @(negedge clk) if (beat === 1'b1) beats++;

    // model: an edge is seen 3 clocks after the pulse; its period is the ms ticks since the last accepted beat
    always @(negedge clk) begin
        int cnt, n, sum;
        if (!rst_n || rc == 0) begin
            q.delete();
            per.delete();
            {m_meas, m_to, m_valid, m_beat} = '0;
            m_bpm = 0; pend_at = -1; a_edge = 0;
        end else begin
            m_beat = 0;
            if (rc == pend_at) begin
                m_bpm = pend_val > 255 ? 255 : pend_val; m_valid = 1; pend_at = -1;
            end
            cnt = (rc - 1) / DIV - a_edge / DIV;
            if (cnt > MAXP) cnt = MAXP;
            if (m_meas && cnt == MAXP) begin
                m_to = 1; m_valid = 0; m_meas = 0; per.delete();
            end else if (q.size() > 0 && q[0] == rc) begin
                if (!m_meas) begin
                    m_beat = 1; m_to = 0; m_meas = 1; a_edge = rc;
                end else if (cnt >= MINP) begin
                    m_beat = 1; a_edge = rc;
                    per.push_back(cnt);
                    n = per.size();
                    if (AVG && n >= 4) begin
                        sum = per[n-1] + per[n-2] + per[n-3] + per[n-4];
                        pend_val = 60000 / (sum / 4); pend_at = rc + 17;
                    end else if (!AVG) begin
                        pend_val = 60000 / cnt; pend_at = rc + 17;
                    end
                end
            end
            while (q.size() > 0 && q[0] <= rc) void'(q.pop_front());
        end
        chk("beat", beat, m_beat);
        chk("bpm", bpm, m_bpm);
        chk("bpm_valid", bpm_valid, m_valid);
        chk("timeout", timeout, m_to);
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ends 3 clocks after the rising edge, i.e. in the cycle where beat is expected
    task automatic fire(input bit late);
        if (late) #8;
        pulse_in = 1'b1;
        q.push_back(rc + 3);
        repeat (3) @(posedge clk);
        #1 pulse_in = 1'b0;
    endtask

    task automatic align;
        if (rc % 2 != 0) wait_cyc(1);
    endtask

    task automatic train(input int n, input int ms, input int el);
        int e = el;
        repeat (n) begin
            wait_cyc(2 * ms - e);
            fire(1'b0);
            e = 3;
        end
    endtask

    initial begin
        int b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bpm", bpm, 0);
        chk("rst_valid", bpm_valid, 0);
        chk("rst_beat", beat, 0);
        chk("rst_timeout", timeout, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        wait_cyc(2);
        align();
        fire(1'b0);
        chk("start_beat", beat, 1);
        train(5, 1000, 3);
        wait_cyc(30);
        chk("bpm60", bpm, 60);
        chk("valid60", bpm_valid, 1);
        // glitch 100 ms after a beat inside the 1000 ms train
        wait_cyc(200 - 33);
        b0 = beats;
        fire(1'b0);
        wait_cyc(100);
        chk("glitch_beats", beats - b0, 0);
        wait_cyc(2000 - 303);
        fire(1'b0);
        chk("beat_lat", beat, 1);
        wait_cyc(30);
        chk("bpm_glitch", bpm, 60);
        // rate step to 500 ms: bpm must hold for 16 cycles after beat and change on the 17th
        wait_cyc(1000 - 33);
        fire(1'b0);
        wait_cyc(16);
        chk("bpm_hold", bpm, 60);
        wait_cyc(1);
        chk("bpm_step", bpm, AVG ? 68 : 120);
        train(4, 500, 20);
        wait_cyc(30);
        chk("bpm120", bpm, 120);
        train(5, 250, 33);
        wait_cyc(30);
        chk("bpm240", bpm, 240);
        chk("valid240", bpm_valid, 1);
        // timeout after 3000 ms without a beat
        wait_cyc(6100);
        chk("to_set", timeout, 1);
        chk("to_valid", bpm_valid, 0);
        chk("to_bpm_hold", bpm, 240);
        align();
        fire(1'b0);
        chk("to_beat", beat, 1);
        chk("to_clear", timeout, 0);
        wait_cyc(30);
        chk("to_noupd_bpm", bpm, 240);
        chk("to_noupd_valid", bpm_valid, 0);
        train(1, 1000, 33);
        wait_cyc(30);
        chk("to_next_bpm", bpm, AVG ? 240 : 60);
        chk("to_next_valid", bpm_valid, AVG ? 0 : 1);
        // asynchronous reset 5 cycles after a beat
        train(1, 1000, 33);
        wait_cyc(5);
        rst_n = 1'b0;
        #1;
        chk("arst_bpm", bpm, 0);
        chk("arst_valid", bpm_valid, 0);
        chk("arst_beat", beat, 0);
        chk("arst_timeout", timeout, 0);
        wait_cyc(3);
        @(negedge clk);
        #1 rst_n = 1'b1;
        wait_cyc(2);
        align();
        fire(1'b0);
        chk("arst_start_beat", beat, 1);
        wait_cyc(30);
        chk("arst_start_bpm", bpm, 0);
        chk("arst_start_valid", bpm_valid, 0);
        train(1, 1000, 33);
        wait_cyc(30);
        chk("arst_next_bpm", bpm, AVG ? 0 : 60);
        chk("arst_next_valid", bpm_valid, AVG ? 0 : 1);
        // pulse edge 1 ns before a clock edge
        wait_cyc(2000 - 33);
        b0 = beats;
        fire(1'b1);
        wait_cyc(20);
        chk("sync_beats", beats - b0, 1);
        wait_cyc(20);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
